// File: rtl/gelu_pkg.sv
// gelu_pkg: shared constants and helpers for the GELU requantisation stage.
package gelu_pkg;
  localparam int SHIFT_W = 6;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;
  localparam logic signed [7:0] INT8_MAX = 8'sh7f;
  function automatic int prod_w(input int acc_w);
    return 2 * acc_w;
  endfunction
endpackage

// File: rtl/requant_core.sv
// requant_core: S1 full-width multiply, S2 round-half-up shift and int8 saturation.
module requant_core
  import gelu_pkg::*;
#(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      v_i,
  input  logic signed [D_W_ACC-1:0] x_i,
  input  logic signed [D_W_ACC-1:0] m_i,
  input  logic        [SHIFT_W-1:0] s_i,
  output logic                      v_o,
  output logic signed [D_W-1:0]     y_o
);
  localparam int PW = prod_w(D_W_ACC);
  logic                 v1_q, v2_q;
  logic signed [PW-1:0] prod_q, half, r;
  logic [SHIFT_W-1:0]   s1_q;
  logic signed [D_W-1:0] y_d, y_q;
  // Shift 0 adds nothing, so one datapath covers both rounding cases
  always_comb begin
    half = (s1_q == '0) ? '0 : PW'(1) << (s1_q - SHIFT_W'(1));
    r    = (prod_q + half) >>> s1_q;
    y_d  = (r > PW'(INT8_MAX)) ? INT8_MAX : (r < PW'(INT8_MIN)) ? INT8_MIN : r[D_W-1:0];
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      prod_q <= '0;
      s1_q   <= '0;
      y_q    <= '0;
    end else if (en) begin
      v1_q   <= v_i;
      prod_q <= PW'(x_i) * PW'(m_i);
      s1_q   <= s_i;
      v2_q   <= v1_q;
      y_q    <= y_d;
    end
  assign v_o = v2_q;
  assign y_o = y_q;
endmodule

// File: rtl/gelu_requant.sv
// gelu_requant: int32 GELU stream -> int8 via per-layer multiplier and shift,
// with matrix-position tlast generation and upstream tlast checking.
module gelu_requant
  import gelu_pkg::*;
#(
  parameter int D_W          = 8,
  parameter int D_W_ACC      = 32,
  parameter int MATRIXSIZE_W = 16,
  parameter int LAYERS       = 12,
  parameter int BATCHES      = 1,
  parameter logic [LAYERS*D_W_ACC-1:0] M_INIT = {LAYERS{D_W_ACC'(1)}},
  parameter logic [LAYERS*SHIFT_W-1:0] S_INIT = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [D_W_ACC-1:0] qin_tdata,
  input  logic                      qin_tlast,
  input  logic                      qin_tvalid,
  output logic                      qin_tready,
  output logic signed [D_W-1:0]     qout_tdata,
  output logic                      qout_tlast,
  output logic                      qout_tvalid,
  input  logic                      qout_tready,
  input  logic [MATRIXSIZE_W-1:0]   DIM1,
  input  logic [MATRIXSIZE_W-1:0]   DIM2,
  output logic                      err_tlast
);
  localparam int LW = LAYERS > 1 ? $clog2(LAYERS) : 1;
  localparam int BW = BATCHES > 1 ? $clog2(BATCHES) : 1;
  localparam logic [MATRIXSIZE_W-1:0] ONE = 1;
  logic en, acc, hs, in_col_end, in_last, out_col_end, out_last, batch_end;
  logic v0_q, bubble_q, bubble_d, err_q, err_d;
  logic signed [D_W_ACC-1:0] x0_q, m0_q, m_rom_q;
  logic [SHIFT_W-1:0] s0_q, s_rom_q;
  logic [MATRIXSIZE_W-1:0] in_col_q, in_col_d, in_row_q, in_row_d;
  logic [MATRIXSIZE_W-1:0] out_col_q, out_col_d, out_row_q, out_row_d;
  logic [LW-1:0] layer_q, layer_d;
  logic [BW-1:0] batch_q, batch_d;
  always_comb begin
    en          = qout_tready | ~qout_tvalid;
    qin_tready  = en & ~bubble_q;
    acc         = qin_tvalid & qin_tready;
    hs          = qout_tvalid & qout_tready;
    in_col_end  = in_col_q == DIM2 - ONE;
    in_last     = in_col_end && in_row_q == DIM1 - ONE;
    out_col_end = out_col_q == DIM2 - ONE;
    out_last    = out_col_end && out_row_q == DIM1 - ONE;
    qout_tlast  = qout_tvalid & out_last;
    in_col_d    = acc ? (in_col_end ? '0 : in_col_q + ONE) : in_col_q;
    in_row_d    = acc && in_col_end ? (in_last ? '0 : in_row_q + ONE) : in_row_q;
    out_col_d   = hs ? (out_col_end ? '0 : out_col_q + ONE) : out_col_q;
    out_row_d   = hs && out_col_end ? (out_last ? '0 : out_row_q + ONE) : out_row_q;
    batch_end   = batch_q == BW'(BATCHES - 1);
    batch_d     = acc && in_last ? (batch_end ? '0 : batch_q + BW'(1)) : batch_q;
    layer_d     = acc && in_last && batch_end ?
                  (layer_q == LW'(LAYERS - 1) ? '0 : layer_q + LW'(1)) : layer_q;
    bubble_d    = acc & in_last;
    err_d       = err_q | (acc & (qin_tlast ^ in_last));
  end
  // ROM outputs reset to layer 0 so a beat right after reset sees valid scales
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      m_rom_q   <= M_INIT[D_W_ACC-1:0];
      s_rom_q   <= S_INIT[SHIFT_W-1:0];
      v0_q      <= 1'b0;
      x0_q      <= '0;
      m0_q      <= '0;
      s0_q      <= '0;
      in_col_q  <= '0;
      in_row_q  <= '0;
      out_col_q <= '0;
      out_row_q <= '0;
      layer_q   <= '0;
      batch_q   <= '0;
      bubble_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      m_rom_q   <= M_INIT[int'(layer_q)*D_W_ACC +: D_W_ACC];
      s_rom_q   <= S_INIT[int'(layer_q)*SHIFT_W +: SHIFT_W];
      if (en) begin
        v0_q <= acc;
        x0_q <= qin_tdata;
        m0_q <= m_rom_q;
        s0_q <= s_rom_q;
      end
      in_col_q  <= in_col_d;
      in_row_q  <= in_row_d;
      out_col_q <= out_col_d;
      out_row_q <= out_row_d;
      layer_q   <= layer_d;
      batch_q   <= batch_d;
      bubble_q  <= bubble_d;
      err_q     <= err_d;
    end
  assign err_tlast = err_q;
  requant_core #(.D_W(D_W), .D_W_ACC(D_W_ACC)) u_core (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .v_i (v0_q),
    .x_i (x0_q),
    .m_i (m0_q),
    .s_i (s0_q),
    .v_o (qout_tvalid),
    .y_o (qout_tdata)
  );
endmodule

// File: tb/tb_gelu_requant.sv
// tb_gelu_requant: directed and random streams against a divide/round/saturate reference model.
module tb_gelu_requant;
  localparam int L = 6;
  localparam logic [L*32-1:0] MI = {32'd12345, -32'sd7, 32'h7fffffff, 32'd1, 32'd1, 32'd3};
  localparam logic [L*6-1:0]  SI = {6'd20, 6'd3, 6'd31, 6'd2, 6'd0, 6'd2};
  int mm [L] = '{3, 1, 1, 32'h7fffffff, -7, 12345};
  int ss [L] = '{2, 0, 2, 31, 3, 20};

  typedef struct { logic signed [7:0] d; logic l; } ex_t;

  logic clk = 0, rst = 0;
  logic signed [31:0] qin_tdata = 0;
  logic qin_tlast = 0, qin_tvalid = 0, qin_tready;
  logic signed [7:0] qout_tdata;
  logic qout_tlast, qout_tvalid, qout_tready = 1;
  logic [15:0] dim1 = 2, dim2 = 2;
  logic err_tlast;

  int total = 0, bad = 0;
  ex_t exq[$];
  logic signed [7:0] obs_d[$];
  logic obs_l[$];
  int m_pos = 0, m_layer = 0;
  logic m_err = 0, bub_chk = 0, hold_v = 0, done = 0;
  logic signed [7:0] hold_d = 0;

  gelu_requant #(.LAYERS(L), .BATCHES(1), .M_INIT(MI), .S_INIT(SI)) dut (
    .clk(clk), .rst(rst),
    .qin_tdata(qin_tdata), .qin_tlast(qin_tlast), .qin_tvalid(qin_tvalid), .qin_tready(qin_tready),
    .qout_tdata(qout_tdata), .qout_tlast(qout_tlast), .qout_tvalid(qout_tvalid), .qout_tready(qout_tready),
    .DIM1(dim1), .DIM2(dim2), .err_tlast(err_tlast)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact rational result q*M/2^S, rounded half toward +inf, then clamped to int8
  function automatic logic signed [7:0] ref_q(input int x, input int layer);
    longint p, fl, rem;
    p   = longint'(x) * longint'(mm[layer]);
    fl  = p >>> ss[layer];
    rem = p - (fl <<< ss[layer]);
    if (2 * rem >= (longint'(1) <<< ss[layer]) && ss[layer] > 0) fl++;
    return fl > 127 ? 8'sh7f : fl < -128 ? 8'sh80 : fl[7:0];
  endfunction

  function automatic int rnd();
    return $urandom_range(0, 3) == 0 ? int'($urandom) : int'($urandom_range(0, 2000)) - 1000;
  endfunction

  always @(negedge clk) begin : mon
    ex_t e;
    if (!rst) begin
      hold_v  = 0;
      bub_chk = 0;
    end else begin
      chk("err_tlast", err_tlast, m_err);
      if (bub_chk) chk("bubble_ready", qin_tready, 1'b0);
      if (hold_v) begin
        chk("hold_valid", qout_tvalid, 1'b1);
        chk("hold_data", qout_tdata, hold_d);
      end
      bub_chk = 0;
      if (qin_tvalid && qin_tready) begin
        e.l = m_pos == int'(dim1) * int'(dim2) - 1;
        e.d = ref_q(qin_tdata, m_layer);
        exq.push_back(e);
        if (qin_tlast !== e.l) m_err = 1;
        if (e.l) begin
          bub_chk = 1;
          m_pos   = 0;
          m_layer = (m_layer + 1) % L;
        end else m_pos++;
      end
      if (qout_tvalid && qout_tready) begin
        obs_d.push_back(qout_tdata);
        obs_l.push_back(qout_tlast);
        chk("out_pending", exq.size() != 0, 1'b1);
        if (exq.size() != 0) begin
          e = exq.pop_front();
          chk("out_data", qout_tdata, e.d);
          chk("out_tlast", qout_tlast, e.l);
        end
      end
      hold_v = qout_tvalid && !qout_tready;
      hold_d = qout_tdata;
    end
  end

  task automatic send(input int d, input bit wrong = 1'b0);
    int t = 0;
    qin_tdata  = d;
    qin_tlast  = (m_pos == int'(dim1) * int'(dim2) - 1) ^ wrong;
    qin_tvalid = 1;
    do begin
      @(negedge clk);
      t++;
    end while (!qin_tready && t < 100);
    if (t >= 100) chk("accept_timeout", qin_tready, 1'b1);
    @(posedge clk);
    #1 qin_tvalid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (exq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", exq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string tag, input int n, input logic signed [7:0] d, input logic l);
    chk({tag, "_present"}, obs_d.size() > n, 1'b1);
    if (obs_d.size() > n) begin
      chk(tag, obs_d[n], d);
      chk({tag, "_tlast"}, obs_l[n], l);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    #2;
    chk("rst_tvalid", qout_tvalid, 1'b0);
    chk("rst_tlast", qout_tlast, 1'b0);
    chk("rst_tdata", qout_tdata, 8'sd0);
    chk("rst_err", err_tlast, 1'b0);
    repeat (2) @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;
    // layer 0 (M=3 S=2), 2x2: latency then scaling
    send(10);
    repeat (2) begin
      @(negedge clk);
      chk("lat_early", qout_tvalid, 1'b0);
    end
    @(negedge clk);
    chk("lat_valid", qout_tvalid, 1'b1);
    chk("lat_data", qout_tdata, 8'sd8);
    @(posedge clk);
    #1;
    send(-10);
    send(0);
    send(7);
    chk("bubble_after_last", qin_tready, 1'b0);
    // layer 1 (M=1 S=0)
    send(5);
    send(1000);
    send(-1000);
    send(rnd());
    drain();
    out_is("s_pos", 0, 8'sd8, 1'b0);
    out_is("s_neg", 1, -8'sd7, 1'b0);
    out_is("s_zero", 2, 8'sd0, 1'b0);
    out_is("s_last", 3, 8'sd5, 1'b1);
    out_is("l1_first", 4, 8'sd5, 1'b0);
    out_is("sat_hi", 5, 8'sd127, 1'b0);
    out_is("sat_lo", 6, 8'sh80, 1'b0);
    // layer 2 (M=1 S=2), 1x3: round half up
    dim1 = 1;
    dim2 = 3;
    b = obs_d.size();
    send(2);
    send(-2);
    send(6);
    drain();
    out_is("rnd_2", b, 8'sd1, 1'b0);
    out_is("rnd_m2", b + 1, 8'sd0, 1'b0);
    out_is("rnd_6", b + 2, 8'sd2, 1'b1);
    // layer 3 (M=0x7fffffff S=31), 1x2
    dim2 = 2;
    b = obs_d.size();
    send(int'(32'h80000000));
    send(rnd());
    drain();
    out_is("min_int", b, 8'sh80, 1'b0);
    // layer 4 (M=-7 S=3), 2x4 with toggling downstream ready
    dim1 = 2;
    dim2 = 4;
    b = obs_d.size();
    done = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(rnd());
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 qout_tready = ~qout_tready;
        end
        qout_tready = 1;
      end
    join
    drain();
    chk("bp_count", obs_d.size() - b, 8);
    // layer 5, 1x4 with a premature upstream tlast on beat 2
    dim1 = 1;
    dim2 = 4;
    send(rnd());
    chk("err_pre", err_tlast, 1'b0);
    send(rnd(), 1'b1);
    chk("err_rise", err_tlast, 1'b1);
    send(rnd());
    send(rnd());
    drain();
    chk("err_sticky", err_tlast, 1'b1);
    // 1x1 matrices: every beat final, bubble after each
    dim2 = 1;
    for (int i = 0; i < 3; i++) begin
      send(rnd());
      chk("bubble_1x1", qin_tready, 1'b0);
    end
    drain();
    // random dims, gaps and downstream ready
    done = 0;
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          dim1 = 16'($urandom_range(1, 3));
          dim2 = 16'($urandom_range(1, 4));
          for (int i = 0; i < int'(dim1) * int'(dim2); i++) begin
            if ($urandom_range(0, 3) == 0) begin
              @(posedge clk);
              #1;
            end
            send(rnd());
          end
          drain();
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 qout_tready = 1'($urandom_range(0, 1));
        end
        qout_tready = 1;
      end
    join
    // asynchronous reset with beats in flight
    dim1 = 2;
    dim2 = 2;
    send(rnd());
    send(rnd());
    send(rnd());
    #2 rst = 0;
    #1;
    chk("mid_rst_tvalid", qout_tvalid, 1'b0);
    chk("mid_rst_tlast", qout_tlast, 1'b0);
    chk("mid_rst_tdata", qout_tdata, 8'sd0);
    chk("mid_rst_err", err_tlast, 1'b0);
    exq.delete();
    m_pos   = 0;
    m_layer = 0;
    m_err   = 0;
    @(posedge clk);
    #3 rst = 1;
    @(posedge clk);
    #1;
    b = obs_d.size();
    send(4);
    send(8);
    send(-4);
    send(1);
    drain();
    out_is("post_rst0", b, 8'sd3, 1'b0);
    out_is("post_rst1", b + 1, 8'sd6, 1'b0);
    out_is("post_rst2", b + 2, -8'sd3, 1'b0);
    out_is("post_rst3", b + 3, 8'sd1, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gelu_requant.md
Name: gelu_requant

Overview:
Requantisation stage directly downstream of the GELU unit. It consumes the 32-bit signed GELU output stream and applies a per-layer fixed-point multiplier, round-half-up right shift and saturation, producing an int8 stream for the next matmul. Scales come from per-layer ROMs. It tracks matrix position to generate tlast, and it checks the incoming tlast against its own beat count.

Parameters:
D_W, 8, output data width (int8)
D_W_ACC, 32, input data width and multiplier width
MATRIXSIZE_W, 16, width of DIM1/DIM2 and the position counters
LAYERS, 12, ROM depth; number of layers
BATCHES, 1, matrices per layer before the layer index advances
M_MEM, "data/gelu/requant_m.mem", per-layer signed 32-bit multiplier
S_MEM, "data/gelu/requant_s.mem", per-layer shift, 6 bits used, range 0..62

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
qin_tdata  in  D_W_ACC  signed GELU result
qin_tlast  in  1  upstream end-of-matrix marker; checked, not forwarded
qin_tvalid  in  1  input valid
qin_tready  out  1  input ready
qout_tdata  out  D_W  signed requantised result
qout_tlast  out  1  asserted on the last beat of a DIM1 x DIM2 matrix
qout_tvalid  out  1  output valid
qout_tready  in  1  downstream ready
DIM1  in  MATRIXSIZE_W  rows; stable for the duration of a matrix
DIM2  in  MATRIXSIZE_W  columns; stable for the duration of a matrix
err_tlast  out  1  sticky flag for a qin_tlast mismatch

Behaviour:
- Reset (rst low, asynchronous):
  - all stage valids, counters, layer, batch and err_tlast clear to 0.
  - qout_tvalid=0, qout_tlast=0, qout_tdata=0.
  - Output is reset-clean mid-matrix; any in-flight beats are dropped.
- Pipeline: three register stages S0 (capture), S1 (multiply), S2 (round/shift/saturate, output register).
  - Global enable en = qout_tready | ~qout_tvalid.
  - All stages advance together when en=1 and hold when en=0.
  - Each stage carries its own valid bit.
  - Latency is 3 cycles from input acceptance to qout_tvalid, with no backpressure.
- Input handshake:
  - qin_tready = en & ~bubble.
  - A beat is accepted when qin_tvalid & qin_tready.
- S0 captures qin_tdata together with the current ROM outputs M and S. Scales travel with the beat, so stalls cannot mix layers.
- Arithmetic:
  - S1: prod = qin * M, full 64-bit signed.
  - S2: if S>0, r = (prod + 2^(S-1)) >>> S; otherwise r = prod.
  - Saturate r to [-128, 127].
  - Rounding is round-half-toward-+inf.
- Input position counters (in_col, in_row):
  - Advance on each accepted beat.
  - in_col wraps at DIM2-1; in_row wraps at DIM1-1.
  - The final beat is in_row==DIM1-1 && in_col==DIM2-1.
- Layer and batch counters:
  - Update on acceptance of the final input beat.
  - batch increments; at BATCHES-1 it wraps to 0 and layer increments.
  - layer wraps at LAYERS-1 to 0.
- ROMs: registered read, address = layer, 1-cycle latency.
- Layer-refresh bubble:
  - After the final input beat is accepted, bubble=1 for exactly one cycle, forcing qin_tready=0.
  - This lets the ROM outputs settle before the next beat is captured.
  - The next matrix's first beat is accepted no earlier than 2 cycles after the final beat.
- Output counters (out_col, out_row):
  - Advance on qout_tvalid & qout_tready, with the same wrap rules.
  - qout_tlast = qout_tvalid && out_row==DIM1-1 && out_col==DIM2-1.
- tlast check:
  - On each accepted beat, err_tlast is set if qin_tlast differs from the final-beat condition.
  - Data flow is unaffected; err_tlast stays set until reset.
- DIM1=DIM2=1: every beat is final; a bubble follows every beat.
- Simultaneous input accept and output handshake in one cycle is normal full-throughput operation: one beat per cycle within a matrix.

Decomposition:
- Shared package gelu_pkg:
  - requant shift width constant (6)
  - product width (2*D_W_ACC)
  - INT8_MIN/INT8_MAX constants
  - ROM file-path defaults
- Reuse the existing rom module (three instances is not needed; two: M, S).
- Reuse the existing counter module for the input and output position counters.
- Natural sub-module: requant_core, containing the S1/S2 arithmetic with en and valid pass-through.

Test Plan:
- Scaling, layer0 M=3 S=2, continuous ready:
  - qin 10 -> 8
  - qin -10 -> -7
  - qin 0 -> 0
  - each appears 3 cycles after acceptance.
- Rounding and saturation:
  - M=1 S=2: qin 2 -> 1, qin -2 -> 0, qin 6 -> 2.
  - M=1 S=0: qin 1000 -> 127, qin -1000 -> -128.
  - M=0x7FFFFFFF S=31: qin -2^31 -> -128.
- Layer switch, DIM1=2 DIM2=2 BATCHES=1, layer1 M=1 S=0:
  - 4th beat is accepted, then qin_tready is 0 for one cycle.
  - Beat 5 (qin 5) -> 5 using layer1 scales.
  - qout_tlast is high on output beat 4 only.
- Backpressure: qout_tready toggles 1010 during an 8-beat stream.
  - No beat is lost or duplicated; order is preserved.
  - qout_tdata is stable while tvalid & ~tready.
- tlast mismatch: DIM1=1 DIM2=4, qin_tlast asserted on beat 2.
  - err_tlast rises the cycle after beat 2 is accepted and stays high.
  - Output data is unaffected.
- Reset mid-matrix: rst low while 3 beats are in flight.
  - qout_tvalid=0 immediately (asynchronous).
  - After release, layer=0 and the counters restart; the next 4-beat matrix gives tlast on its 4th output beat.
